scoreboard_display: RTL and testbench

//  Sits downstream of the game-logic block. It drives the 4-digit 7-segment display from that block's lives[1:0] and score[3:0] outputs.

---
 rtl/scoreboard_display.sv | 263 ++++++++++++++++++++++++++
 tb/tb_scoreboard_display.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_display.sv
// scoreboard_display
//   Drives a 4-digit, active-low, time-multiplexed 7-segment display from the
//   game-logic block's lives/score outputs. Those inputs come from a slower,
//   unrelated clock. Each one is synchronised, and the pair is committed only
//   after it has been stable for a while. Commits that change the game
//   situation (score up, life lost, game over, new game) start timed blink
//   effects through a small FSM.
//   Digit layout: dig3 = lives, dig2 = blank, dig1:dig0 = score in decimal.
//
// Ports
//   clk        display clock
//   rst_n      asynchronous active-low reset
//   lives[1:0] lives from game logic (asynchronous to clk)
//   score[3:0] score 0..15 from game logic (asynchronous to clk)
//   an[3:0]    digit anodes, active-low, one-hot-low
//   seg[6:0]   segments {g,f,e,d,c,b,a}, active-low
//   game_over  high while the FSM is in GAME_OVER
//
// The FSM state is held in the enum-typed signal 'state'.
module scoreboard_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int STABLE_CYC   = 4,
  parameter int FLASH_CYCLES = 50000000,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] lives,
  input  logic [3:0] score,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       game_over
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = $clog2(STABLE_CYC + 1);

  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW:0]   STB        = (SW + 1)'(STABLE_CYC);

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    SCORE_FLASH = 2'd1,
    HIT_FLASH   = 2'd2,
    GAME_OVER   = 2'd3
  } state_t;

  // The synchronisers reset to the committed reset values. If they reset
  // to zero, the filter would see lives=0 right after reset and declare a
  // spurious game over.
  logic [1:0] lives_s1, lives_s2;
  logic [3:0] score_s1, score_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives_s1 <= 2'd3;
      lives_s2 <= 2'd3;
      score_s1 <= 4'd0;
      score_s2 <= 4'd0;
    end else begin
      lives_s1 <= lives;
      lives_s2 <= lives_s1;
      score_s1 <= score;
      score_s2 <= score_s1;
    end
  end

  // Stability filter. 'run' counts consecutive identical synced samples,
  // including the current one. A commit fires exactly once, when the run
  // reaches STABLE_CYC. Re-committing an unchanged value is harmless
  // because it raises no event.
  logic [5:0]    samp, cand;
  logic [SW-1:0] stab_cnt;
  logic [SW:0]   run;
  logic          commit;

  assign samp   = {lives_s2, score_s2};
  assign run    = (samp == cand) ? ({1'b0, stab_cnt} + 1'b1) : (SW + 1)'(1);
  assign commit = (run == STB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= {2'd3, 4'd0};
      stab_cnt <= '0;
    end else begin
      cand <= samp;
      if (run <= STB) stab_cnt <= run[SW-1:0];
    end
  end

  logic [1:0] lives_c;
  logic [3:0] score_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives_c <= 2'd3;
      score_c <= 4'd0;
    end else if (commit) begin
      lives_c <= samp[5:4];
      score_c <= samp[3:0];
    end
  end

  // Events compare the value being committed with the value it replaces.
  logic ev_go, ev_newg, ev_hit, ev_scr;

  assign ev_go   = commit && (samp[5:4] == 2'd0);
  assign ev_newg = commit && (samp[5:4] > lives_c);
  assign ev_hit  = commit && (samp[5:4] < lives_c) && (samp[5:4] != 2'd0);
  assign ev_scr  = commit && (samp[3:0] > score_c);

  state_t        state, state_nx;
  logic          enter;
  logic [FW-1:0] flash_cnt;
  logic          flash_done;
  logic          in_flash;

  assign in_flash   = (state == SCORE_FLASH) || (state == HIT_FLASH);
  assign flash_done = (flash_cnt == FLASH_LAST);

  // 'enter' marks any event-driven transition, self re-triggers included.
  // It restarts the flash timer and the blink phase.
  always_comb begin
    state_nx = state;
    enter    = 1'b0;
    if (ev_go) begin
      state_nx = GAME_OVER;
      enter    = 1'b1;
    end else if (state == GAME_OVER) begin
      if (ev_newg) begin
        state_nx = NORMAL;
        enter    = 1'b1;
      end
    end else if (ev_newg) begin
      state_nx = NORMAL;
      enter    = 1'b1;
    end else if (ev_hit) begin
      state_nx = HIT_FLASH;
      enter    = 1'b1;
    end else if (ev_scr) begin
      state_nx = SCORE_FLASH;
      enter    = 1'b1;
    end else if (in_flash && flash_done) begin
      state_nx = NORMAL;
      enter    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NORMAL;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flash_cnt <= '0;
    else if (enter)    flash_cnt <= '0;
    else if (in_flash) flash_cnt <= flash_cnt + 1'b1;
  end

  logic          blink_on;
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (enter) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  logic [RW-1:0] ref_cnt;
  logic [1:0]    idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // The score never exceeds 15, so the decimal split is a single compare.
  logic       ge10;
  logic [3:0] ones, tens;
  logic [3:0] dig_val;
  logic       dig_blank;

  assign ge10 = (score_c >= 4'd10);
  assign ones = ge10 ? (score_c - 4'd10) : score_c;
  assign tens = {3'b000, ge10};

  always_comb begin
    dig_val   = 4'd0;
    dig_blank = 1'b1;
    case (idx)
      2'd0: begin
        dig_val   = ones;
        dig_blank = 1'b0;
      end
      2'd1: begin
        dig_val   = tens;
        dig_blank = !ge10;
      end
      2'd3: begin
        dig_val   = {2'b00, lives_c};
        dig_blank = 1'b0;
      end
      default: dig_blank = 1'b1;
    endcase
    if (!blink_on) begin
      case (state)
        SCORE_FLASH: if (!idx[1])      dig_blank = 1'b1;
        HIT_FLASH:   if (idx == 2'd3)  dig_blank = 1'b1;
        GAME_OVER:                     dig_blank = 1'b1;
        default:                       ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= dig_blank ? 7'h7F : seg_code(dig_val);
    end
  end

  assign game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_scoreboard_display.sv
// tb_scoreboard_display
//   Directed bench for scoreboard_display using small timing parameters.
//   Each step drives new inputs and pushes the expected {game_over, an, seg}
//   for every cycle of a window into exp_q. The values come from a
//   closed-form model that works from the commit time and the state-entry
//   time. The step then pops the queue and compares against the DUT at
//   each falling edge.
module tb_scoreboard_display;

  localparam int REFRESH_DIV  = 4;
  localparam int STABLE_CYC   = 2;
  localparam int FLASH_CYCLES = 32;
  localparam int BLINK_DIV    = 8;
  localparam int LAT          = 2 + STABLE_CYC;

  localparam int ST_NORMAL = 0;
  localparam int ST_SCORE  = 1;
  localparam int ST_HIT    = 2;
  localparam int ST_GO     = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] lives;
  logic [3:0] score;
  logic [3:0] an;
  logic [6:0] seg;
  logic       game_over;

  scoreboard_display #(
    .REFRESH_DIV  (REFRESH_DIV),
    .STABLE_CYC   (STABLE_CYC),
    .FLASH_CYCLES (FLASH_CYCLES),
    .BLINK_DIV    (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lives     (lives),
    .score     (score),
    .an        (an),
    .seg       (seg),
    .game_over (game_over)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Reference model: current (m_*) and previous (o_*) committed situation.
  // The current one takes effect from edge commit_at.
  int m_lives, m_score, m_state, m_entry;
  int o_lives, o_score, o_state, o_entry;
  int commit_at;

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] exp_q[$];

  function automatic int eff_state(input int st, input int entry, input int e);
    if ((st == ST_SCORE || st == ST_HIT) && e >= entry + FLASH_CYCLES) return ST_NORMAL;
    return st;
  endfunction

  // Expected {game_over, an, seg} at the falling edge after rising edge n.
  // an/seg show what was selected after edge n-1; game_over follows edge n.
  function automatic logic [11:0] expect_at(input int n);
    int lv, sc, st, en, e, idx, d, gst;
    logic on, blank, go;
    logic [3:0] a;
    logic [6:0] s;
    e = n - 1;
    if (e >= commit_at) begin
      lv = m_lives; sc = m_score; st = m_state; en = m_entry;
    end else begin
      lv = o_lives; sc = o_score; st = o_state; en = o_entry;
    end
    st    = eff_state(st, en, e);
    on    = (((e - en) / BLINK_DIV) % 2) == 0;
    idx   = (e / REFRESH_DIV) % 4;
    blank = 1'b0;
    d     = 0;
    case (idx)
      0: d = sc % 10;
      1: begin d = sc / 10; blank = (sc < 10); end
      2: blank = 1'b1;
      default: d = lv;
    endcase
    if (!on && (st == ST_GO || (st == ST_SCORE && idx < 2) || (st == ST_HIT && idx == 3)))
      blank = 1'b1;
    s = blank ? 7'h7F : seg_tab[d];
    a = ~(4'b0001 << idx);
    if (n >= commit_at) gst = eff_state(m_state, m_entry, n);
    else                gst = eff_state(o_state, o_entry, n);
    go = (gst == ST_GO);
    return {go, a, s};
  endfunction

  task automatic model_reset();
    m_lives = 3; m_score = 0; m_state = ST_NORMAL; m_entry = 0;
    o_lives = 3; o_score = 0; o_state = ST_NORMAL; o_entry = 0;
    commit_at = 0;
  endtask

  // New committed value (l, s) lands at edge c; apply the event rules.
  task automatic model_commit(input int l, input int s, input int c);
    int cur;
    cur = eff_state(m_state, m_entry, c - 1);
    o_lives = m_lives; o_score = m_score; o_state = m_state; o_entry = m_entry;
    commit_at = c;
    if (l == 0) begin
      m_state = ST_GO; m_entry = c;
    end else if (cur == ST_GO) begin
      if (l > m_lives) begin m_state = ST_NORMAL; m_entry = c; end
    end else if (l > m_lives) begin
      m_state = ST_NORMAL; m_entry = c;
    end else if (l < m_lives) begin
      m_state = ST_HIT; m_entry = c;
    end else if (s > m_score) begin
      m_state = ST_SCORE; m_entry = c;
    end else begin
      m_state = cur;
    end
    m_lives = l;
    m_score = s;
  endtask

  // scoreboard
  task automatic push_window(input int k, input int w);
    for (int i = 1; i <= w; i++) exp_q.push_back(expect_at(k + i));
  endtask

  task automatic drain(input int w, input string tag);
    logic [11:0] e, o;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $error("FAIL %s cyc=%0d observed=queue-empty expected=entry", tag, cyc);
      end else begin
        e = exp_q.pop_front();
        o = {game_over, an, seg};
        assert (o === e) else begin
          miscompares++;
          $error("FAIL %s cyc=%0d observed go/an/seg=%b/%b/%b expected=%b/%b/%b",
                 tag, cyc, o[11], o[10:7], o[6:0], e[11], e[10:7], e[6:0]);
        end
      end
    end
  endtask

  task automatic check_reset_now(input string tag);
    logic [11:0] e, o;
    exp_q.push_back({1'b0, 4'b1111, 7'h7F});
    e = exp_q.pop_front();
    o = {game_over, an, seg};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed go/an/seg=%b/%b/%b expected=%b/%b/%b",
             tag, o[11], o[10:7], o[6:0], e[11], e[10:7], e[6:0]);
    end
  endtask

  // driver
  task automatic apply(input int l, input int s, input int w, input string tag);
    int k;
    @(negedge clk);
    lives = 2'(l);
    score = 4'(s);
    k = cyc;
    model_commit(l, s, k + LAT);
    push_window(k, w);
    drain(w, tag);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    lives = 2'd3;
    score = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_now("reset_hold");

    // Release: lives=3 shows on dig3, 0 on dig0, dig1/dig2 blank.
    rst_n = 1'b1;
    push_window(0, 20);
    drain(20, "idle_after_reset");

    apply(3, 9, 40, "score_0_to_9");
    apply(3, 12, 48, "score_9_to_12_flash");
    apply(2, 12, 48, "hit_3_to_2");
    apply(1, 3, 40, "hit_2_to_1");
    apply(0, 4, 48, "game_over_go_wins");
    apply(3, 4, 24, "new_game");
    apply(3, 5, 40, "score_4_to_5");

    // Single-cycle glitch on score must not commit.
    @(negedge clk);
    score = 4'd6;
    @(negedge clk);
    score = 4'd5;
    k = cyc;
    commit_at = 0;
    push_window(k, 24);
    drain(24, "glitch_ignored");

    // Asynchronous reset in the middle of a hit flash.
    apply(2, 5, 12, "hit_before_reset");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_now("async_reset_mid_flash");
    @(negedge clk);
    lives = 2'd2;
    score = 4'd7;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_commit(2, 7, LAT);
    push_window(0, 48);
    drain(48, "after_async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
